// File: rtl/mam_mem_responder.sv
// rtl/mam_mem_responder.sv - MAM memory-side responder backed by a word-addressed array
// Services single/burst reads and byte-strobed writes; out-of-range beats are dropped or read as zero.
module mam_mem_responder #(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    MEM_WORDS  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_rw,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    req_burst,
  input  logic [13:0]             req_beats,
  input  logic                    write_valid,
  output logic                    write_ready,
  input  logic [DATA_WIDTH-1:0]   write_data,
  input  logic [DATA_WIDTH/8-1:0] write_strb,
  output logic                    read_valid,
  output logic [DATA_WIDTH-1:0]   read_data,
  input  logic                    read_ready
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(MEM_WORDS);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);
  // One extra bit so the top of the window cannot overflow at full address width.
  localparam logic [ADDR_WIDTH:0]   RANGE_LO   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_WIDTH:0]   RANGE_HI   = RANGE_LO + (ADDR_WIDTH+1)'(MEM_WORDS) * (ADDR_WIDTH+1)'(BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [13:0]           beats_left;

  logic                  req_fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  last_beat;
  logic [ADDR_WIDTH-1:0] req_addr_al;
  logic [13:0]           req_len;
  logic [IDX_W-1:0]      wr_idx;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= RANGE_LO) && ({1'b0, a} < RANGE_HI);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return off[OFF_W +: IDX_W];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fetch(input logic [ADDR_WIDTH-1:0] a);
    return in_range(a) ? mem[word_idx(a)] : '0;
  endfunction

  assign req_fire    = req_valid & req_ready;
  assign wr_fire     = write_valid & write_ready;
  assign rd_fire     = read_valid & read_ready;
  assign last_beat   = (beats_left == 14'd1);
  assign req_addr_al = req_addr & ALIGN_MASK;
  assign req_len     = (req_burst && (req_beats != 14'd0)) ? req_beats : 14'd1;
  assign wr_idx      = word_idx(cur_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    write_ready = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = ~rst;
        if (req_valid && !rst) begin
          state_nxt = req_rw ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        write_ready = 1'b1;
        if (wr_fire && last_beat) begin
          state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        if (rd_fire && last_beat) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // cur_addr always points at the next beat to touch the array; reads prefetch one beat ahead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_addr   <= '0;
      beats_left <= '0;
      read_valid <= 1'b0;
      read_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            beats_left <= req_len;
            if (req_rw) begin
              cur_addr <= req_addr_al;
            end else begin
              cur_addr   <= req_addr_al + STEP;
              read_data  <= fetch(req_addr_al);
              read_valid <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (wr_fire) begin
            cur_addr   <= cur_addr + STEP;
            beats_left <= beats_left - 14'd1;
          end
        end
        S_READ: begin
          if (rd_fire) begin
            if (last_beat) begin
              read_valid <= 1'b0;
            end else begin
              read_data  <= fetch(cur_addr);
              cur_addr   <= cur_addr + STEP;
              beats_left <= beats_left - 14'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && in_range(cur_addr)) begin
      for (int b = 0; b < BYTES; b++) begin
        if (write_strb[b]) begin
          mem[wr_idx][8*b +: 8] <= write_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mam_mem_responder.sv
// tb/tb_mam_mem_responder.sv - self-checking bench for mam_mem_responder
// Directed vector table, corner-case sequences and randomized traffic against a byte-level memory model.
module tb_mam_mem_responder;

  localparam logic [63:0] TB_BASE = 64'h0;
  localparam logic [63:0] TB_SPAN = 64'd1024 * 64'd8;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [63:0] req_addr;
  logic        req_burst;
  logic [13:0] req_beats;
  logic        write_valid;
  logic        write_ready;
  logic [63:0] write_data;
  logic [7:0]  write_strb;
  logic        read_valid;
  logic [63:0] read_data;
  logic        read_ready;

  int n_chk = 0;
  int n_err = 0;

  logic [63:0] wd_q[$];
  logic [7:0]  ws_q[$];
  logic [63:0] rd_q[$];

  logic [63:0] ref_mem [1024];
  logic [7:0]  ref_known [1024];

  typedef struct {
    logic        rw;
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[13];

  mam_mem_responder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_burst  (req_burst),
    .req_beats  (req_beats),
    .write_valid(write_valid),
    .write_ready(write_ready),
    .write_data (write_data),
    .write_strb (write_strb),
    .read_valid (read_valid),
    .read_data  (read_data),
    .read_ready (read_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit addr_in_range(input logic [63:0] a);
    return (a >= TB_BASE) && ((a - TB_BASE) < TB_SPAN);
  endfunction

  function automatic void model_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
    int idx;
    if (addr_in_range(a)) begin
      idx = int'((a - TB_BASE) / 64'd8);
      for (int b = 0; b < 8; b++) begin
        if (s[b]) begin
          ref_mem[idx][8*b +: 8] = d[8*b +: 8];
          ref_known[idx][b]      = 1'b1;
        end
      end
    end
  endfunction

  function automatic bit model_read(input logic [63:0] a, output logic [63:0] d);
    int idx;
    d = 64'h0;
    if (!addr_in_range(a)) return 1'b1;
    idx = int'((a - TB_BASE) / 64'd8);
    d = ref_mem[idx];
    return ref_known[idx] == 8'hFF;
  endfunction

  task automatic send_req(input logic rw, input logic [63:0] addr, input logic burst, input logic [13:0] beats);
    int w = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = addr;
    req_burst = burst;
    req_beats = beats;
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk("req_accept_timeout", 64'(w), 64'd0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("busy_req_ready", req_ready, 1'b0);
  endtask

  task automatic do_write(input logic [63:0] addr, input logic burst, input logic [13:0] beats, input int n, input bit gaps);
    logic [63:0] base;
    base = addr & ~64'h7;
    send_req(1'b1, addr, burst, beats);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        write_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      write_valid = 1'b1;
      write_data  = wd_q[i];
      write_strb  = ws_q[i];
      chk("wr_ready", write_ready, 1'b1);
      @(negedge clk);
      model_write(base + 64'(i) * 64'd8, wd_q[i], ws_q[i]);
    end
    write_valid = 1'b0;
    chk("wr_end_write_ready", write_ready, 1'b0);
    chk("wr_end_req_ready", req_ready, 1'b1);
  endtask

  task automatic do_read(input logic [63:0] addr, input logic burst, input logic [13:0] beats, input int n, input int mode);
    int          got = 0;
    int          cyc = 0;
    logic        prev_hold = 1'b0;
    logic [63:0] prev = '0;
    rd_q.delete();
    send_req(1'b0, addr, burst, beats);
    chk("rd_first_latency", read_valid, 1'b1);
    while (got < n && cyc < 2000) begin
      if (prev_hold) begin
        chk("rd_hold_valid", read_valid, 1'b1);
        chk("rd_hold_data", read_data, prev);
      end
      case (mode)
        0:       read_ready = 1'b1;
        1:       read_ready = (cyc % 2 == 0);
        default: read_ready = 1'($urandom_range(0, 1));
      endcase
      if (read_valid && read_ready) begin
        rd_q.push_back(read_data);
        got++;
      end
      prev_hold = read_valid && !read_ready;
      prev      = read_data;
      @(negedge clk);
      cyc++;
    end
    read_ready = 1'b0;
    if (got < n) chk("rd_beat_timeout", 64'(got), 64'(n));
    chk("rd_end_valid", read_valid, 1'b0);
    chk("rd_end_req_ready", req_ready, 1'b1);
  endtask

  task automatic load_one(input logic [63:0] d, input logic [7:0] s);
    wd_q.delete();
    ws_q.delete();
    wd_q.push_back(d);
    ws_q.push_back(s);
  endtask

  initial begin
    logic [63:0] exp_d;
    logic [63:0] a;
    logic [63:0] base;
    logic        burst;
    logic [13:0] beats;
    int          n;

    vecs[0]  = '{1'b1, 64'h10, 64'h1122334455667788, 8'hFF, 64'h0};
    vecs[1]  = '{1'b0, 64'h10, 64'h0, 8'h00, 64'h1122334455667788};
    vecs[2]  = '{1'b1, 64'h00, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0};
    vecs[3]  = '{1'b1, 64'h00, 64'h00000000000000AA, 8'h01, 64'h0};
    vecs[4]  = '{1'b0, 64'h00, 64'h0, 8'h00, 64'hFFFFFFFFFFFFFFAA};
    vecs[5]  = '{1'b0, 64'h17, 64'h0, 8'h00, 64'h1122334455667788};
    vecs[6]  = '{1'b1, 64'h2000, 64'hDEADBEEFDEADBEEF, 8'hFF, 64'h0};
    vecs[7]  = '{1'b0, 64'h2000, 64'h0, 8'h00, 64'h0};
    vecs[8]  = '{1'b0, 64'h00, 64'h0, 8'h00, 64'hFFFFFFFFFFFFFFAA};
    vecs[9]  = '{1'b1, 64'h18, 64'h0, 8'hFF, 64'h0};
    vecs[10] = '{1'b1, 64'h1C, 64'h0123456789ABCDEF, 8'h3C, 64'h0};
    vecs[11] = '{1'b0, 64'h18, 64'h0, 8'h00, 64'h0000456789AB0000};
    vecs[12] = '{1'b0, 64'h10, 64'h0, 8'h00, 64'h1122334455667788};

    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = '0;
    end

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_rw      = 1'b0;
    req_addr    = '0;
    req_burst   = 1'b0;
    req_beats   = '0;
    write_valid = 1'b0;
    write_data  = '0;
    write_strb  = '0;
    read_ready  = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_write_ready", write_ready, 1'b0);
    chk("rst_read_valid", read_valid, 1'b0);
    chk("rst_read_data", read_data, 64'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", req_ready, 1'b1);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].rw) begin
        load_one(vecs[i].data, vecs[i].strb);
        do_write(vecs[i].addr, 1'b0, 14'd0, 1, 1'b0);
      end else begin
        do_read(vecs[i].addr, 1'b0, 14'd0, 1, 0);
        chk($sformatf("vec%0d_read", i), rd_q.size() > 0 ? rd_q[0] : 64'hX, vecs[i].exp);
      end
    end

    wd_q.delete();
    ws_q.delete();
    for (int i = 0; i < 8; i++) begin
      wd_q.push_back(64'(i + 1));
      ws_q.push_back(8'hFF);
    end
    do_write(64'h100, 1'b1, 14'd8, 8, 1'b1);
    do_read(64'h100, 1'b1, 14'd8, 8, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("burst_beat%0d", i), rd_q.size() > i ? rd_q[i] : 64'hX, 64'(i + 1));

    wd_q = '{64'h1111, 64'h2222};
    ws_q = '{8'hFF, 8'hFF};
    do_write(64'h0, 1'b1, 14'd2, 2, 1'b0);
    wd_q = '{64'hA1, 64'hA2, 64'hA3, 64'hA4};
    ws_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_write(64'h1FF0, 1'b1, 14'd4, 4, 1'b0);
    do_read(64'h1FF0, 1'b1, 14'd4, 4, 0);
    chk("top_beat0", rd_q.size() > 0 ? rd_q[0] : 64'hX, 64'hA1);
    chk("top_beat1", rd_q.size() > 1 ? rd_q[1] : 64'hX, 64'hA2);
    chk("top_beat2_oor", rd_q.size() > 2 ? rd_q[2] : 64'hX, 64'h0);
    chk("top_beat3_oor", rd_q.size() > 3 ? rd_q[3] : 64'hX, 64'h0);
    do_read(64'h0, 1'b1, 14'd2, 2, 0);
    chk("nowrap_word0", rd_q.size() > 0 ? rd_q[0] : 64'hX, 64'h1111);
    chk("nowrap_word1", rd_q.size() > 1 ? rd_q[1] : 64'hX, 64'h2222);

    wd_q = '{64'hB1, 64'hB2, 64'hB3};
    ws_q = '{8'hFF, 8'hFF, 8'hFF};
    do_write(64'hFFFFFFFFFFFFFFF8, 1'b1, 14'd3, 3, 1'b0);
    do_read(64'hFFFFFFFFFFFFFFF8, 1'b1, 14'd3, 3, 2);
    chk("addrwrap_beat0", rd_q.size() > 0 ? rd_q[0] : 64'hX, 64'h0);
    chk("addrwrap_beat1", rd_q.size() > 1 ? rd_q[1] : 64'hX, 64'hB2);
    chk("addrwrap_beat2", rd_q.size() > 2 ? rd_q[2] : 64'hX, 64'hB3);

    do_read(64'h100, 1'b1, 14'd0, 1, 0);
    chk("beats0_count", 64'(rd_q.size()), 64'd1);
    chk("beats0_data", rd_q.size() > 0 ? rd_q[0] : 64'hX, 64'h1);
    load_one(64'h5A5A5A5A5A5A5A5A, 8'hFF);
    do_write(64'h20, 1'b0, 14'd5, 1, 1'b0);
    do_read(64'h20, 1'b0, 14'd0, 1, 0);
    chk("single_ignores_beats", rd_q.size() > 0 ? rd_q[0] : 64'hX, 64'h5A5A5A5A5A5A5A5A);

    send_req(1'b0, 64'h100, 1'b1, 14'd8);
    read_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_read_valid", read_valid, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    read_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_req_ready", req_ready, 1'b1);
    chk("postrst_read_valid", read_valid, 1'b0);
    @(negedge clk);
    do_read(64'h10, 1'b0, 14'd0, 1, 0);
    chk("postrst_data", rd_q.size() > 0 ? rd_q[0] : 64'hX, 64'h1122334455667788);

    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 64'($urandom_range(0, 1023)) * 64'd8;
        7, 8:                a = 64'($urandom_range(1016, 1023)) * 64'd8;
        default:             a = 64'h3000 + 64'($urandom_range(0, 63)) * 64'd8;
      endcase
      a     = a + 64'($urandom_range(0, 7));
      base  = a & ~64'h7;
      burst = 1'($urandom_range(0, 1));
      beats = 14'($urandom_range(0, 12));
      n     = burst ? ((beats == 14'd0) ? 1 : int'(beats)) : 1;
      if ($urandom_range(0, 1) == 1) begin
        wd_q.delete();
        ws_q.delete();
        for (int i = 0; i < n; i++) begin
          wd_q.push_back({$urandom, $urandom});
          ws_q.push_back(8'($urandom));
        end
        do_write(a, burst, beats, n, 1'b1);
      end else begin
        do_read(a, burst, beats, n, 2);
        for (int i = 0; i < n && i < rd_q.size(); i++) begin
          if (model_read(base + 64'(i) * 64'd8, exp_d)) begin
            chk($sformatf("rand%0d_beat%0d", t, i), rd_q[i], exp_d);
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mam_mem_responder.md
Name: mam_mem_responder

Overview:
- Memory-side responder for the MAM memory-access request interface. Services the single/burst read and write requests issued by the debug memory access module from a local word-addressed register array.
- Used as a standalone debug-accessible scratch memory and as the reference target for verifying MAM traffic in simulation.
- Handles byte strobes, beat counting, address increment and out-of-range accesses.

Parameters:
DATA_WIDTH, 64, beat width in bits; multiple of 8; BYTES = DATA_WIDTH/8
ADDR_WIDTH, 64, byte-address width of req_addr
BASE_ADDR, 0, byte address of word 0; BYTES-aligned
MEM_WORDS, 1024, array depth in DATA_WIDTH words; power of two

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when high with req_valid
req_rw  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH  byte start address; low log2(BYTES) bits ignored
req_burst  in  1  1 = burst of req_beats beats, 0 = single beat
req_beats  in  14  burst length in beats
write_valid  in  1  write beat valid
write_ready  out  1  write beat accepted
write_data  in  DATA_WIDTH  write beat data
write_strb  in  DATA_WIDTH/8  byte enables, bit i controls byte i
read_valid  out  1  read beat valid
read_data  out  DATA_WIDTH  read beat data
read_ready  in  1  read beat consumed

Behaviour:
- Reset (async assert): FSM enters IDLE; req_ready=0 during reset, then 1 in IDLE; write_ready=0, read_valid=0, read_data=0. Array contents are not reset.
- Reset mid-burst: the burst is abandoned immediately. Remaining beats are neither accepted nor produced.
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch word index = (req_addr-BASE_ADDR)>>log2(BYTES) and beat count.
  - Beat count = req_burst ? req_beats : 1. req_beats=0 with req_burst=1 is treated as 1.
  - Go to WRITE if req_rw=1, else READ.
- WRITE:
  - req_ready=0, write_ready=1.
  - Each write_valid&write_ready edge writes bytes with strb=1 at the current index, leaves the other bytes untouched, index+1, count-1.
  - On the last beat, return to IDLE; req_ready=1 the next cycle.
  - write_valid low stalls indefinitely with no timeout.
- READ:
  - req_ready=0.
  - The edge after acceptance loads read_data from the start index and sets read_valid=1; first-beat latency is 1 cycle.
  - read_data/read_valid hold stable while read_ready=0.
  - On read_valid&read_ready, the same edge loads the next word (index+1) if beats remain, giving full throughput of 1 beat/cycle. Otherwise read_valid goes to 0 and the FSM returns to IDLE.
- Range: a beat is in range when BASE_ADDR <= beat byte address < BASE_ADDR+MEM_WORDS*BYTES, computed at full ADDR_WIDTH with no wrap in the array.
  - Out-of-range write beats are accepted and discarded.
  - Out-of-range read beats return all zeros.
  - A burst crossing the top of the range continues with the remaining beats out of range.
- Index arithmetic: ADDR_WIDTH-bit byte address advances by BYTES per beat and wraps modulo 2^ADDR_WIDTH. The 14-bit counter covers bursts of up to 16383 beats.
- No request is accepted while WRITE or READ is active. A new request is accepted at the earliest one cycle after the last beat.
- write_valid asserted in IDLE or READ is ignored (write_ready=0).

Test Plan:
1. Single write, then read: write addr 0x10, data 0x1122334455667788, strb 0xFF; then single read of 0x10 -> read_valid one cycle after acceptance, read_data 0x1122334455667788.
2. Strobe merge: word 0x0 preloaded with 0xFFFFFFFFFFFFFFFF; write 0x00000000000000AA with strb 0x01 -> read returns 0xFFFFFFFFFFFFFF00 | 0xAA = 0xFFFFFFFFFFFFFFAA.
3. Burst with backpressure: burst write of 8 beats at 0x100, data i+1 per beat; burst read of 8 beats with read_ready toggling 1,0,1,0.
   - Required: data 1..8 in order.
   - read_data stable while read_ready=0.
   - req_ready returns 1 one cycle after beat 8.
4. Boundary: burst write of 4 beats at 0x1FF0 (words 1022, 1023, then out of range); read back 4 beats -> first two values, then 0, 0. Words 0 and 1 are unchanged (no wrap).
5. Degenerate length: req_burst=1, req_beats=0 read -> exactly one beat produced; req_burst=0, req_beats=5 write -> exactly one beat accepted, write_ready drops after it.
6. Reset mid-burst: assert rst after 3 of 8 read beats -> read_valid=0 and req_ready=0 asynchronously, req_ready=1 after release; a previously written word still reads back correctly.
